// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared state, opcode and select encodings for the multicycle
//               MIPS main control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] ALUB_REG     = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mc_next_state.sv
// ============================================================================
// Module      : mc_next_state
// Description : Combinational next-state decode for the multicycle control FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_next_state
    import mips_ctrl_pkg::*;
#(
    parameter bit OP_ADDI_EN = 1'b1
) (
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic [3:0] o_next_state
);

    always_comb begin
        o_next_state = S_FETCH;
        case (i_state)
            S_FETCH:     o_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: o_next_state = S_MEM_ADDR;
                    OP_RTYPE:     o_next_state = S_EXECUTE;
                    OP_BEQ:       o_next_state = S_BRANCH;
                    OP_J:         o_next_state = S_JUMP;
                    OP_ADDI:      o_next_state = OP_ADDI_EN ? S_ADDI_EXEC : S_TRAP;
                    default:      o_next_state = S_TRAP;
                endcase
            end
            // Opcode is re-sampled; anything that is no longer lw/sw traps rather than writing
            S_MEM_ADDR: begin
                if (i_opcode == OP_LW)
                    o_next_state = S_MEM_READ;
                else if (i_opcode == OP_SW)
                    o_next_state = S_MEM_WRITE;
                else
                    o_next_state = S_TRAP;
            end
            S_MEM_READ:  o_next_state = i_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: o_next_state = i_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   o_next_state = S_ALU_WB;
            S_ADDI_EXEC: o_next_state = S_ADDI_WB;
            default:     o_next_state = S_FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_main_control.sv
// ============================================================================
// Module      : multicycle_main_control
// Description : Main control FSM for the multicycle MIPS datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit OP_ADDI_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     r_state;
    logic       r_illegal;
    logic [3:0] w_next_state;
    logic       w_mem_ready;

    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign w_mem_ready = mem_ready;
        end else begin : g_no_mem_wait
            assign w_mem_ready = 1'b1;
        end
    endgenerate

    mc_next_state #(
        .OP_ADDI_EN (OP_ADDI_EN)
    ) u_next_state (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_mem_ready  (w_mem_ready),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= state_t'(w_next_state);
            if (w_next_state == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;
    assign state_o    = r_state;

    // Moore decode; gated by rst_n so nothing is asserted while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = w_mem_ready;
                    pc_write  = w_mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ALUB_IMM_SH2;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// ============================================================================
// Module      : tb_multicycle_main_control
// Description : Scoreboard bench for the multicycle MIPS main control FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    wire [15:0] ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_ill  = 1'b0;

    // Reference control word per state, written from the state table
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] ps, sbs, aop;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
        ps = 2'd0; sbs = 2'd0; aop = 2'd0;
        case (st)
            4'd0:  begin mrd = 1; sbs = 2'd1; irw = mr; pw = mr; end
            4'd1:  sbs = 2'd3;
            4'd2:  begin sa = 1; sbs = 2'd2; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iod = 1; end
            4'd6:  begin sa = 1; aop = 2'd2; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
            4'd9:  begin pw = 1; ps = 2'd2; end
            4'd10: begin sa = 1; sbs = 2'd2; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rd, rw, sa, sbs, aop};
    endfunction

    task automatic push(input logic [5:0] op, input logic mr, input logic [3:0] st);
        exp_t x;
        if (st == 4'd12) exp_ill = 1'b1;
        x.op = op; x.mr = mr; x.st = st; x.ctrl = exp_ctrl(st, mr); x.ill = exp_ill;
        sb.push_back(x);
    endtask

    // Expected per-cycle trace of one instruction; mem_ready is random where it must be ignored
    task automatic queue_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(op, 1'b0, 4'd0);
        push(op, 1'b1, 4'd0);
        push(op, 1'($urandom_range(0, 1)), 4'd1);
        case (op)
            6'h23: begin
                push(op, 1'($urandom_range(0, 1)), 4'd2);
                for (int i = 0; i < mw; i++) push(op, 1'b0, 4'd3);
                push(op, 1'b1, 4'd3);
                push(op, 1'($urandom_range(0, 1)), 4'd4);
            end
            6'h2B: begin
                push(op, 1'($urandom_range(0, 1)), 4'd2);
                for (int i = 0; i < mw; i++) push(op, 1'b0, 4'd5);
                push(op, 1'b1, 4'd5);
            end
            6'h00: begin push(op, 1'($urandom_range(0, 1)), 4'd6); push(op, 1'($urandom_range(0, 1)), 4'd7); end
            6'h04: push(op, 1'($urandom_range(0, 1)), 4'd8);
            6'h02: push(op, 1'($urandom_range(0, 1)), 4'd9);
            6'h08: begin push(op, 1'($urandom_range(0, 1)), 4'd10); push(op, 1'($urandom_range(0, 1)), 4'd11); end
            default: push(op, 1'($urandom_range(0, 1)), 4'd12);
        endcase
    endtask

    task automatic tick(input logic [5:0] op, input logic mr);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== 21'd0) begin
                n_errors++;
                $display("FAIL reset_hold: state %0d ctrl %h ill %b, expected all 0", state_o, ctrl, illegal_op);
            end
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({state_o, ctrl, illegal_op} !== {4'd0, exp_ctrl(4'd0, 1'b0), 1'b0}) begin
            n_errors++;
            $display("FAIL reset_release: state %0d ctrl %h ill %b, expected state 0 ctrl %h ill 0",
                     state_o, ctrl, illegal_op, exp_ctrl(4'd0, 1'b0));
        end
    endtask

    task automatic test_lw;
        int n_wb = 0;
        queue_instr(6'h23, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL lw: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
            if (reg_write && mem_to_reg) n_wb++;
        end
        n_checks++;
        if (n_wb != 1) begin
            n_errors++;
            $display("FAIL lw_writeback_count: got %0d, expected 1", n_wb);
        end
    endtask

    task automatic test_sw_wait;
        int n_mw = 0, n_rw = 0;
        queue_instr(6'h2B, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL sw_wait: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
            n_mw += int'(mem_write);
            n_rw += int'(reg_write);
        end
        n_checks++;
        if (n_mw != 4 || n_rw != 0) begin
            n_errors++;
            $display("FAIL sw_counts: mem_write %0d reg_write %0d, expected 4 and 0", n_mw, n_rw);
        end
    endtask

    task automatic test_fetch_wait;
        int n_ir = 0;
        queue_instr(6'h00, 2, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL fetch_wait: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
            if (ir_write && pc_write) n_ir++;
        end
        n_checks++;
        if (n_ir != 1) begin
            n_errors++;
            $display("FAIL fetch_ir_write_count: got %0d, expected 1", n_ir);
        end
    endtask

    task automatic test_branch_jump_addi;
        queue_instr(6'h04, 0, 0);
        queue_instr(6'h02, 0, 0);
        queue_instr(6'h08, 1, 0);
        queue_instr(6'h23, 1, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL back_to_back: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
        end
    endtask

    task automatic test_illegal;
        queue_instr(6'h3F, 0, 0);
        queue_instr(6'h23, 0, 1);
        queue_instr(6'h04, 0, 0);
        queue_instr(6'h11, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL illegal: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
        end
    endtask

    task automatic test_reset_mid;
        push(6'h23, 1'b1, 4'd0);
        push(6'h23, 1'b0, 4'd1);
        push(6'h23, 1'b0, 4'd2);
        push(6'h23, 1'b0, 4'd3);
        push(6'h23, 1'b0, 4'd3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL pre_reset: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
        end
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({state_o, ctrl, illegal_op} !== 21'd0) begin
            n_errors++;
            $display("FAIL mid_reset_assert: state %0d ctrl %h ill %b, expected all 0", state_o, ctrl, illegal_op);
        end
        @(negedge clk);
        n_checks++;
        if ({state_o, ctrl, illegal_op} !== 21'd0) begin
            n_errors++;
            $display("FAIL mid_reset_hold: state %0d ctrl %h ill %b, expected all 0", state_o, ctrl, illegal_op);
        end
        mem_ready = 1'b0;
        exp_ill   = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({state_o, ctrl, illegal_op} !== {4'd0, exp_ctrl(4'd0, 1'b0), 1'b0}) begin
            n_errors++;
            $display("FAIL mid_reset_release: state %0d ctrl %h ill %b, expected state 0 ctrl %h ill 0",
                     state_o, ctrl, illegal_op, exp_ctrl(4'd0, 1'b0));
        end
        queue_instr(6'h02, 0, 0);
        queue_instr(6'h00, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.op, e.mr);
            n_checks++;
            if ({state_o, ctrl, illegal_op} !== {e.st, e.ctrl, e.ill}) begin
                n_errors++;
                $display("FAIL post_reset: state %0d ctrl %h ill %b, expected state %0d ctrl %h ill %b",
                         state_o, ctrl, illegal_op, e.st, e.ctrl, e.ill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_branch_jump_addi();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back over several clocks per instruction.
- Drives every datapath mux select and write enable: PC, IR, register file, memory, and ALU-operation class to the ALU control.
- Waits on a memory ready handshake so variable-latency memory can be attached.
- Flags unsupported opcodes.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = mem_ready is treated as constant 1.
- OP_ADDI_EN, 1: 1 = addi is decoded; 0 = addi is treated as illegal.

Ports:
- clk  in  1  system clock; the state register updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct field.
- illegal_op  out  1  sticky unsupported-opcode flag.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset, asynchronous (rst_n=0): state=FETCH (0); illegal_op=0.
- While rst_n=0, every control output is forced 0 and state_o=0.
- Reset mid-instruction abandons the instruction. No partial write may follow reset release.
- After reset release, the first active cycle is FETCH.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12. Codes 13-15 go to FETCH next cycle with all outputs 0.
- Outputs are Moore decodes of state, except pc_write and ir_write, which are gated by mem_ready. Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0. Next state by opcode:
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x00 -> EXECUTE.
  - 0x04 -> BRANCH.
  - 0x02 -> JUMP.
  - 0x08 -> ADDI_EXEC (only if OP_ADDI_EN=1).
  - Any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEM_READ for 0x23, MEM_WRITE for 0x2B. Opcode is sampled again here.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=2. Next: ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=2. Next: FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- TRAP: sets illegal_op=1 (cleared only by reset); no writes. Next: FETCH. PC has already advanced, so the bad instruction is skipped.
- Cycles per instruction, zero wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
- Timing: the datapath's negedge write-destination delay stage samples reg_dst-selected addresses mid-cycle, so all outputs must be stable within half a clock of posedge. No output is registered an extra stage.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state typedef/localparams.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - alu_op codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - alu_src_b and pc_source encodings.
- One natural sub-module: mc_next_state (combinational next-state decode). Output decode stays in the top module.

Test Plan:
- rst_n=0 mid-MEM_READ, then released -> all outputs 0 during reset; state_o=0; first active cycle FETCH with mem_read=1.
- lw (0x23), mem_ready tied 1 -> state_o 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; 5 cycles.
- sw (0x2B), mem_ready low for 3 cycles in MEM_WRITE -> mem_write=1 held 4 cycles; total 7 cycles; reg_write never 1.
- Fetch with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 for 2 cycles, then both 1 for exactly 1 cycle; DECODE next.
- beq (0x04) then j (0x02) -> BRANCH: pc_write_cond=1, alu_op=1, pc_source=1; JUMP: pc_write=1, pc_source=2; each instruction 3 cycles.
- opcode 0x3F -> DECODE, TRAP, FETCH; illegal_op rises and stays 1 through subsequent valid instructions until rst_n=0.
